// File: rtl/regfile_pkg.sv
// Shared constants, reset-value table and clear FSM states
// for the multi-port integer register file.
package regfile_pkg;

  localparam logic [31:0] SP_RESET = 32'h0000_01F4;
  localparam logic [31:0] GP_RESET = 32'h1000_0000;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  // Architectural reset value of register idx
  function automatic logic [31:0] reset_value(input int idx);
    logic [31:0] v;
    v = 32'h0;
    if (idx == 2) v = SP_RESET;
    if (idx == 3) v = GP_RESET;
    return v;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: address mux, x0 zeroing,
// same-edge write bypass compare and output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_regs [NREGS],
  input  logic [AW-1:0]   i_raddr,
  input  logic            i_byp_en,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] r_rdata;

  always_comb begin
    w_data = i_regs[i_raddr];
    if (i_raddr == '0)
      w_data = '0;
    else if (i_byp_en && (i_waddr == i_raddr))
      w_data = i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rdata <= '0;
    else
      r_rdata <= w_data;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / 1-write register file with sequential clear engine.
// Define REGFILE_BYPASS_EN for same-edge write-to-read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                clr_req,
  output logic                clr_busy
);

  clr_state_e      r_state;
  clr_state_e      w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;
  logic            w_byp_en;
  logic            w_last;

  assign w_wr_en  = we && (waddr != '0) && (r_state == IDLE);
  assign w_last   = (r_idx == AW'(NREGS - 1));
  assign clr_busy = (r_state == CLEAR);

`ifdef REGFILE_BYPASS_EN
  assign w_byp_en = w_wr_en;
`else
  assign w_byp_en = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (clr_req) w_state_nxt = CLEAR;
      CLEAR: if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_idx <= '0;
    else if ((r_state == IDLE) && clr_req)
      r_idx <= AW'(1);
    else if (r_state == CLEAR)
      r_idx <= r_idx + AW'(1);
  end

  // x0 is never a write target, so entry 0 stays at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= XLEN'(reset_value(i));
    end else if (r_state == CLEAR) begin
      r_regs[r_idx] <= XLEN'(reset_value(32'(r_idx)));
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .i_regs   (r_regs),
      .i_raddr  (raddr[p*AW +: AW]),
      .i_byp_en (w_byp_en),
      .i_waddr  (waddr),
      .i_wdata  (wdata),
      .o_rdata  (rdata[p*XLEN +: XLEN])
    );
  end

endmodule
